// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: presents a single-port synchronous memory as a valid/ready FIFO
// with a one-entry output register that is refilled by a two-cycle read.
module mem_fifo_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH:0]   level,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DWIDTH-1:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, RD, RD_CAP} state_t;
  state_t state, state_nx;
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0] cnt;
  logic prefetch;
  // Refilling an empty output register takes priority over accepting a push.
  assign prefetch = state == IDLE && !out_valid && |cnt;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == RD ? RD_CAP : state == RD_CAP ? IDLE : prefetch ? RD : IDLE;
  always_comb begin
    in_ready    = rst_ && state == IDLE && !prefetch && cnt != (AWIDTH+1)'(DEPTH);
    mem_write   = in_valid && in_ready;
    mem_read    = state == RD;
    mem_addr    = mem_write ? wr_ptr : mem_read ? rd_ptr : '0;
    mem_data_in = mem_write ? in_data : '0;
    level       = cnt + {{AWIDTH{1'b0}}, out_valid};
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr <= mem_write ? wr_ptr + 1'b1 : wr_ptr;
      cnt    <= mem_write ? cnt + 1'b1 : state == RD_CAP ? cnt - 1'b1 : cnt;
      if (state == RD_CAP) begin
        out_data  <= mem_data_out;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: randomized scoreboard bench with a behavioural 32x8 memory;
// a negedge monitor checks pops against a byte queue and the level/ready rules.
module tb_mem_fifo_ctrl;
  logic clk = 0, rst_ = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0, out_data, mem_data_in, mem_data_out;
  logic in_ready, out_valid, mem_read, mem_write;
  logic [5:0] level;
  logic [4:0] mem_addr;
  logic [7:0] mem [32];
  logic [7:0] q [$];
  int compared = 0, mismatched = 0, pop_cnt = 0;

  mem_fifo_ctrl dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addr];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Scoreboard monitor: the queue holds every accepted byte not yet popped.
  always @(negedge clk) begin
    if (!rst_) q.delete();
    else begin
      chk("level", level, q.size());
      chk("in_ready", in_ready, out_valid ? (q.size() - 1 < 32) : (q.size() == 0));
      chk("wr_when_accept", mem_write, in_valid && in_ready);
      chk("rw_exclusive", mem_read && mem_write, 0);
      if (out_valid) chk("no_read_while_valid", mem_read, 0);
      if (!mem_read && !mem_write) chk("idle_bus", {mem_addr, mem_data_in}, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_empty", 1, 0);
        else chk("pop_data", out_data, q.pop_front());
        pop_cnt++;
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  task automatic push_byte(input logic [7:0] d);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk) ok = in_ready;
      @(posedge clk) #1;
    end
    if (!ok) chk("push_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 600 && (q.size() != 0 || out_valid); i++) @(posedge clk) #1;
    chk("drain_empty", q.size(), 0);
    out_ready = 0;
  endtask

  task automatic random_run(input int n, input bit seq);
    int target = pop_cnt + n;
    fork
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk) #1;
        push_byte(seq ? 8'(i) : 8'($urandom));
      end
      for (int g = 0; g < 8000 && pop_cnt < target; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk) #1;
      end
    join
    out_ready = 0;
    chk("random_pops", pop_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    in_valid = 1;
    in_data = 8'h55;
    repeat (2) begin
      @(negedge clk);
      chk("rst_outputs", {in_ready, out_valid, out_data, level, mem_read, mem_write, mem_addr, mem_data_in}, 0);
    end
    @(posedge clk) #1;
    in_valid = 0;
    rst_ = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_level", level, 0);
    @(posedge clk) #1;
    // Single byte: check bus in push cycle and the three-edge latency.
    in_valid = 1;
    in_data = 8'hA5;
    @(negedge clk);
    chk("push_bus", {mem_write, mem_addr, mem_data_in}, {1'b1, 5'd0, 8'hA5});
    @(posedge clk) #1;
    in_valid = 0;
    chk("lat_e1", out_valid, 0);
    @(posedge clk) #1;
    @(negedge clk);
    chk("rd_bus", {mem_read, mem_addr}, {1'b1, 5'd0});
    @(posedge clk) #1;
    chk("lat_e2", out_valid, 0);
    @(posedge clk) #1;
    chk("lat_e3", {out_valid, out_data, level}, {1'b1, 8'hA5, 6'd1});
    repeat (2) @(posedge clk) #1;
    chk("hold_level", level, 1);
    drain();
    // Fill to full: one byte in the output register plus 32 in memory.
    for (int i = 0; i <= 32; i++) push_byte(8'(i));
    repeat (4) @(posedge clk) #1;
    in_valid = 1;
    in_data = 8'h21;
    repeat (3) begin
      @(negedge clk);
      chk("full_level", level, 33);
      chk("full_ready", in_ready, 0);
      chk("full_no_write", mem_write, 0);
    end
    @(posedge clk) #1;
    out_ready = 1;
    @(posedge clk) #1;
    out_ready = 0;
    push_byte(8'h21);
    drain();
    // Wrap with sequential bytes, then a longer fully random run.
    random_run(40, 1);
    random_run(150, 0);
    drain();
    // Back-pressure: the output byte must hold and no read may start.
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk) #1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", {out_valid, out_data}, {1'b1, 8'h3C});
      chk("bp_no_read", mem_read, 0);
    end
    @(posedge clk) #1;
    drain();
    // Reset during the RD cycle abandons the read.
    push_byte(8'h99);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) @(negedge clk) found = mem_read;
    chk("rd_seen", found, 1);
    #2 rst_ = 0;
    #1 chk("midrd_rst", {mem_read, out_valid, level, in_ready}, 0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_ = 1;
    push_byte(8'h7E);
    for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk) #1;
    chk("first_after_rst", {out_valid, out_data}, {1'b1, 8'h7E});
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
